led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N_LED, default 8, number of LED outputs; the block SHALL support any N_LED >= 2.
REQ-002 Parameter TICK_DIV, default 12_500_000, clock cycles per pattern step; the block SHALL support any TICK_DIV >= 2.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, synchronous reset, active-low; it SHALL be sampled only on the rising edge of clk.
REQ-005 Port mode, input, 3, pattern select; the block SHALL register it internally as mode_q.
REQ-006 Port pause, input, 1, SHALL freeze the pattern and the prescaler while high.
REQ-007 Port led, output, N_LED, current pattern, registered.
REQ-008 Port tick, output, 1, SHALL pulse high for exactly one cycle at each step boundary.

Function
REQ-009 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be 1 when count==TICK_DIV-1 and pause==0.
REQ-010 led SHALL change only on the edge where tick==1 or where a mode load occurs.
REQ-011 A mode load SHALL occur on any edge where mode!=mode_q; it SHALL take priority over pause and tick.
REQ-012 On a mode load, mode_q SHALL take the value of mode, the prescaler and the step state SHALL clear, and led SHALL take the new mode's initial pattern.
REQ-013 Mode 0 (SHL) SHALL start at 0..01, rotate left one bit per tick, and wrap from bit N_LED-1 to bit 0.
REQ-014 Mode 1 (SHR) SHALL start at 10..0, rotate right one bit per tick, and wrap from bit 0 to bit N_LED-1.
REQ-015 Mode 2 (BAR) SHALL keep a level L from 0 to N_LED with led=(1<<L)-1; L SHALL step up to N_LED, then down to 0, then repeat, giving a period of 2*N_LED ticks.
REQ-016 Mode 3 (CNT) SHALL start at 0 and increment modulo 2^N_LED per tick.
REQ-017 Mode 4 (PING) SHALL start at 0..01 with a single dot moving left; at bit N_LED-1 the next step SHALL be N_LED-2; at bit 0 the next step SHALL be bit 1; the period SHALL be 2*(N_LED-1) ticks.
REQ-018 Mode 5 (BLINK) SHALL start with all ones and toggle between all ones and all zeros per tick.
REQ-019 Modes 6 and 7 SHALL drive led to all zeros and hold it there.
REQ-020 While pause==1 with no mode change, led, the step state and the prescaler SHALL all hold; on release, counting SHALL resume from the held values.

Reset
REQ-021 With reset==0 at an edge, led SHALL be 0, tick SHALL be 0, the prescaler and step state SHALL be 0, and mode_q SHALL be 3'b111.
REQ-022 On the first edge after reset releases, a mode load SHALL occur, because mode_q (3'b111) differs from any mode other than 7.
REQ-023 Reset asserted mid-pattern SHALL take effect on that same edge, overriding tick, pause and any mode load.

Structure
REQ-024 The mode encodings (SHL, SHR, BAR, CNT, PING, BLINK, OFF) SHALL be constants in a shared package, led_pkg.
REQ-025 The prescaler SHALL be a sub-module, tick_gen, with inputs clk, reset, clr and en, and output tick.
REQ-026 The counter widths SHALL be derived with $clog2 from TICK_DIV and N_LED; no width SHALL be hard-coded.

Verification (N_LED=8, TICK_DIV=4)
REQ-027 Hold reset=0 with mode=0, then release: led=00, then 01 one cycle later, then 02 four cycles after that, continuing to 80 and wrapping to 01; tick SHALL pulse every 4 cycles.
REQ-028 Mode 4: led=80 SHALL be followed by 40, and 01 SHALL be followed by 02; the sequence SHALL repeat every 14 ticks.
REQ-029 Mode 2: led SHALL run 00,01,03,...,FF,7F,...,01,00 over a 16-tick period.
REQ-030 Mode 3 running at led=05, switch mode to 1 mid-period: led=80 on the next edge, 40 four cycles later, and no tick in between.
REQ-031 Mode 3, pause high for 10 cycles: led SHALL stay constant and tick SHALL stay 0; after release, the next increment SHALL occur after the remaining prescaler count.
REQ-032 Assert reset mid-BLINK: led=00 on that edge; after release with mode=6, led SHALL remain 00 indefinitely.

Source files
------------

// File: rtl/led_pkg.sv
// Mode encodings shared by the LED pattern generator
// and its bench.
package led_pkg;

  localparam logic [2:0] MODE_SHL   = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_BAR   = 3'd2;
  localparam logic [2:0] MODE_CNT   = 3'd3;
  localparam logic [2:0] MODE_PING  = 3'd4;
  localparam logic [2:0] MODE_BLINK = 3'd5;
  localparam logic [2:0] MODE_OFF   = 3'd6;
  // Reset value of mode_q, forces a load on release
  localparam logic [2:0] MODE_RST   = 3'd7;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled,
// tick marks the last count of each period.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == MAX);
  assign tick   = en & w_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: seven selectable patterns
// stepped by a prescaled tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int LW = $clog2(N_LED + 1);

  logic [2:0]       r_mode_q;
  logic [N_LED-1:0] r_led;
  logic [LW-1:0]    r_lvl;
  logic             r_dir;

  logic             w_load;
  logic             w_tick;
  logic [N_LED-1:0] w_init;
  logic [N_LED-1:0] w_nxt_led;
  logic [LW-1:0]    w_nxt_lvl;
  logic             w_nxt_dir;

  assign w_load = (mode != r_mode_q);
  assign led    = r_led;
  assign tick   = w_tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_load),
    .en   (~pause),
    .tick (w_tick)
  );

  always_comb begin
    w_init = '0;
    unique case (mode)
      MODE_SHL:   w_init = N_LED'(1);
      MODE_SHR:   w_init = {1'b1, {(N_LED-1){1'b0}}};
      MODE_PING:  w_init = N_LED'(1);
      MODE_BLINK: w_init = '1;
      default:    w_init = '0;
    endcase
  end

  always_comb begin
    w_nxt_led = r_led;
    w_nxt_lvl = r_lvl;
    w_nxt_dir = r_dir;
    unique case (r_mode_q)
      MODE_SHL: w_nxt_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
      MODE_SHR: w_nxt_led = {r_led[0], r_led[N_LED-1:1]};
      MODE_BAR: begin
        // dir=0 climbs toward N_LED, dir=1 falls toward 0
        if (!r_dir) begin
          w_nxt_lvl = r_lvl + LW'(1);
          w_nxt_dir = (r_lvl == LW'(N_LED - 1));
        end else begin
          w_nxt_lvl = r_lvl - LW'(1);
          w_nxt_dir = (r_lvl != LW'(1));
        end
        w_nxt_led = ~({N_LED{1'b1}} << w_nxt_lvl);
      end
      MODE_CNT: w_nxt_led = r_led + N_LED'(1);
      MODE_PING: begin
        if (!r_dir) begin
          if (r_led[N_LED-1]) begin
            w_nxt_led = {1'b0, r_led[N_LED-1:1]};
            w_nxt_dir = 1'b1;
          end else begin
            w_nxt_led = {r_led[N_LED-2:0], 1'b0};
          end
        end else begin
          if (r_led[0]) begin
            w_nxt_led = {r_led[N_LED-2:0], 1'b0};
            w_nxt_dir = 1'b0;
          end else begin
            w_nxt_led = {1'b0, r_led[N_LED-1:1]};
          end
        end
      end
      MODE_BLINK: w_nxt_led = ~r_led;
      MODE_OFF:   w_nxt_led = '0;
      MODE_RST:   w_nxt_led = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode_q <= MODE_RST;
      r_led    <= '0;
      r_lvl    <= '0;
      r_dir    <= 1'b0;
    end else if (w_load) begin
      r_mode_q <= mode;
      r_led    <= w_init;
      r_lvl    <= '0;
      r_dir    <= 1'b0;
    end else if (w_tick) begin
      r_led    <= w_nxt_led;
      r_lvl    <= w_nxt_lvl;
      r_dir    <= w_nxt_dir;
    end
  end

endmodule
